// File: rtl/spi_slave_core.sv
// SPI mode-0 responder: oversamples sclk/ss_n/mosi in the clk domain, receives
// fixed-length MSB-first frames and shifts out a preloaded (or idle) word.
module spi_slave_core #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_error,
  output logic [1:0]            fsm_state
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_WAIT_END = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Handshake: tx_load is a single-cycle strobe with no ready; it is always
  // accepted. rx_valid and frame_error are single-cycle strobes with no
  // backpressure; rx_data holds until the next completed frame.

  logic [2:0] sclk_sync;
  logic [2:0] ss_sync;
  logic [1:0] mosi_sync;

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_pending_q, tx_pending_d;
  logic [DATA_WIDTH-1:0] rx_data_d;
  logic                  miso_d, miso_oe_d, tx_busy_d, rx_valid_d, frame_error_d;
  logic [DATA_WIDTH-1:0] frame_word;

  // ss_n synchronisers reset to "selected" so a frame already in progress at
  // reset release produces no fall event and is skipped from WAIT_END.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= 3'b000;
      ss_sync   <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      ss_sync   <= {ss_sync[1:0], ss_n};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sclk_rise =  sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] &  sclk_sync[2];
  assign ss_fall   = ~ss_sync[1]   &  ss_sync[2];
  assign ss_rise   =  ss_sync[1]   & ~ss_sync[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT_END;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      tx_buf_q     <= IDLE_WORD;
      tx_pending_q <= 1'b0;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      tx_busy      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      tx_buf_q     <= tx_buf_d;
      tx_pending_q <= tx_pending_d;
      miso         <= miso_d;
      miso_oe      <= miso_oe_d;
      tx_busy      <= tx_busy_d;
      rx_data      <= rx_data_d;
      rx_valid     <= rx_valid_d;
      frame_error  <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    tx_buf_d      = tx_buf_q;
    tx_pending_d  = tx_pending_q;
    miso_d        = miso;
    miso_oe_d     = miso_oe;
    tx_busy_d     = tx_busy;
    rx_data_d     = rx_data;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;
    frame_word    = IDLE_WORD;

    if (tx_load) begin
      tx_buf_d     = tx_data;
      tx_pending_d = 1'b1;
    end

    if (tx_load)           frame_word = tx_data;
    else if (tx_pending_q) frame_word = tx_buf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d      = ST_ACTIVE;
          tx_shift_d   = frame_word;
          miso_d       = frame_word[DATA_WIDTH-1];
          miso_oe_d    = 1'b1;
          tx_busy_d    = 1'b1;
          bit_cnt_d    = '0;
          tx_pending_d = 1'b0;
        end
      end

      ST_ACTIVE: begin
        if (bit_cnt_q == CNT_FULL) begin
          // Completion wins over any ss_n rise seen this or the previous cycle;
          // the synchronised level tells whether to skip WAIT_END.
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          miso_d     = 1'b0;
          if (ss_sync[1]) begin
            state_d   = ST_IDLE;
            miso_oe_d = 1'b0;
            tx_busy_d = 1'b0;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_WAIT_END;
          end
        end else if (ss_rise && !(sclk_rise && bit_cnt_q == CNT_LAST)) begin
          frame_error_d = 1'b1;
          state_d       = ST_IDLE;
          miso_d        = 1'b0;
          miso_oe_d     = 1'b0;
          tx_busy_d     = 1'b0;
          bit_cnt_d     = '0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync[1]};
            bit_cnt_d  = bit_cnt_q + CW'(1);
          end
          if (sclk_fall) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            miso_d     = tx_shift_q[DATA_WIDTH-2];
          end
        end
      end

      ST_WAIT_END: begin
        miso_d = 1'b0;
        if (ss_sync[1]) begin
          state_d   = ST_IDLE;
          miso_oe_d = 1'b0;
          tx_busy_d = 1'b0;
          bit_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_WAIT_END;
      end
    endcase
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a bit-banged SPI master drives frames and a
// word-level model predicts received words, strobes and the master's read-back.
module tb_spi_slave_core;

  localparam int W = 32;
  localparam logic [W-1:0] IDLE_WORD = 32'h0000_0000;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT_END = 2'd2;

  logic         clk = 1'b0;
  logic         reset;
  logic         sclk, ss_n, mosi;
  logic         miso, miso_oe;
  logic [W-1:0] tx_data;
  logic         tx_load;
  logic         tx_busy;
  logic [W-1:0] rx_data;
  logic         rx_valid, frame_error;
  logic [1:0]   fsm_state;

  spi_slave_core #(.DATA_WIDTH(W), .IDLE_WORD(IDLE_WORD)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_error(frame_error), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_buf = IDLE_WORD;
  bit           m_pending = 0;
  logic [W-1:0] last_rx = '0;
  int           exp_rx = 0, exp_err = 0;
  int           rx_seen = 0, err_seen = 0;

  // scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        rx_seen++;
        if (exp_q.size() == 0) check("rx_unexpected", rx_valid, 1'b0);
        else check("rx_data", rx_data, exp_q.pop_front());
      end
      if (frame_error) err_seen++;
    end
  end

  // drivers
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load_tx(input logic [W-1:0] w);
    tx_data = w;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
    m_buf = w;
    m_pending = 1;
  endtask

  task automatic do_frame(input logic [W-1:0] word, input int nbits, input int half,
                          input bit race, input logic [W-1:0] race_word,
                          input int rst_at, input bit ss_with_last);
    logic [W-1:0] got, exp_tx;
    int nb;
    bit dead, killed;
    got = '0;
    dead = 0;
    killed = (rst_at >= 0 && rst_at < nbits);
    nb = killed ? rst_at : ((nbits < W) ? nbits : W);
    exp_tx = race ? race_word : (m_pending ? m_buf : IDLE_WORD);
    m_pending = 0;
    if (!killed) begin
      if (nbits >= W) begin
        exp_q.push_back(word);
        exp_rx++;
        last_rx = word;
      end else begin
        exp_err++;
      end
    end

    wait_clk(1);
    ss_n = 1'b0;
    if (race) begin
      wait_clk(2);
      tx_data = race_word;
      tx_load = 1'b1;
      wait_clk(1);
      tx_load = 1'b0;
      wait_clk(half - 3);
    end else begin
      wait_clk(half);
    end

    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        #1 reset = 1'b1;
        #2;
        check("rst_miso", miso, 1'b0);
        check("rst_miso_oe", miso_oe, 1'b0);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_rx_data", rx_data, '0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        check("rst_state", fsm_state, S_WAIT_END);
        wait_clk(2);
        reset = 1'b0;
        m_pending = 0;
        m_buf = IDLE_WORD;
        last_rx = '0;
        dead = 1;
      end
      mosi = (i < W) ? word[W-1-i] : 1'($urandom_range(0, 1));
      wait_clk(half);
      if (i < W && !dead) begin
        got = {got[W-2:0], miso};
        check("miso_oe", miso_oe, 1'b1);
        check("tx_busy", tx_busy, 1'b1);
      end else begin
        check("miso_quiet", miso, 1'b0);
      end
      sclk = 1'b1;
      if (ss_with_last && i == nbits - 1) ss_n = 1'b1;
      wait_clk(half);
      sclk = 1'b0;
    end
    if (!ss_with_last) begin
      wait_clk(half);
      ss_n = 1'b1;
    end
    wait_clk(10);

    check("rx_count", rx_seen, exp_rx);
    check("err_count", err_seen, exp_err);
    check("rx_hold", rx_data, last_rx);
    if (nb > 0) check("tx_word", got, exp_tx >> (W - nb));
    check("busy_end", tx_busy, 1'b0);
    check("oe_end", miso_oe, 1'b0);
    check("state_end", fsm_state, S_IDLE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    int kind, nbits;
    bit race;
    reset = 1'b1;
    sclk = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    tx_data = '0;
    tx_load = 1'b0;
    wait_clk(3);
    check("reset_miso", miso, 1'b0);
    check("reset_miso_oe", miso_oe, 1'b0);
    check("reset_tx_busy", tx_busy, 1'b0);
    check("reset_rx_data", rx_data, '0);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_error", frame_error, 1'b0);
    check("reset_state", fsm_state, S_WAIT_END);
    reset = 1'b0;
    wait_clk(6);
    check("idle_after_reset", fsm_state, S_IDLE);

    // basic frame
    load_tx(32'hA5A5_0F0F);
    do_frame(32'h1234_5678, 32, 6, 0, '0, -1, 0);
    // back-to-back, nothing loaded
    do_frame(32'hDEAD_BEEF, 32, 6, 0, '0, -1, 0);
    do_frame(32'hCAFE_F00D, 32, 6, 0, '0, -1, 0);
    // abort after 17 bits, then a full frame
    load_tx(32'h1357_9BDF);
    do_frame(32'hFFFF_FFFF, 17, 6, 0, '0, -1, 0);
    do_frame(32'h0000_0001, 32, 6, 0, '0, -1, 0);
    // over-clocked frame
    load_tx(32'hF0F0_3C3C);
    do_frame(32'h89AB_CDEF, 40, 6, 0, '0, -1, 0);
    // reset mid-frame, released with ss_n low
    load_tx(32'h7777_1111);
    do_frame(32'h2468_ACE0, 32, 6, 0, '0, 10, 0);
    do_frame(32'h5555_AAAA, 32, 6, 0, '0, -1, 0);
    // load coinciding with the ss_n-fall event
    do_frame(32'h0BAD_CAFE, 32, 6, 1, 32'h8000_0001, -1, 0);
    do_frame(32'h1111_2222, 32, 6, 0, '0, -1, 0);
    // ss_n rises together with the final sclk rise
    load_tx(32'hC001_D00D);
    do_frame(32'h3141_5926, 32, 5, 0, '0, -1, 1);

    // randomized frames
    for (int r = 0; r < 24; r++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 1) nbits = $urandom_range(1, 31);
      else if (kind == 2) nbits = $urandom_range(33, 40);
      else nbits = 32;
      if ($urandom_range(0, 1) == 1) load_tx($urandom);
      race = ($urandom_range(0, 5) == 0);
      w = $urandom;
      do_frame(w, nbits, $urandom_range(5, 8), race, $urandom, -1,
               (nbits == 32) && ($urandom_range(0, 4) == 0));
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- SPI responder (mode 0, CPOL=0/CPHA=0, MSB first, fixed DATA_WIDTH-bit frames); the far end of the team's SPI master link.
- Oversamples sclk, ss_n and mosi in the local clk domain.
- Delivers each received word on a one-cycle rx_valid strobe.
- Shifts out a word preloaded by local logic via a tx_load strobe. Used in the SPI endpoint/bridge and as a loopback target for the master.

Parameters:
DATA_WIDTH, 32, frame length in bits, also the rx/tx word width
IDLE_WORD, 32'h0000_0000, word transmitted when nothing was loaded since the previous frame

Ports:
clk  input  1  system clock; must be at least 10x the sclk frequency
reset  input  1  asynchronous, active-high reset
sclk  input  1  SPI clock from master (asynchronous to clk)
ss_n  input  1  SPI slave select, active low (asynchronous)
mosi  input  1  SPI data from master (asynchronous)
miso  output  1  SPI data to master
miso_oe  output  1  miso output enable (1 while selected)
tx_data  input  DATA_WIDTH  word for a following frame
tx_load  input  1  one-cycle strobe; captures tx_data
tx_busy  output  1  frame in progress
rx_data  output  DATA_WIDTH  last complete received word
rx_valid  output  1  one-cycle strobe: rx_data updated
frame_error  output  1  one-cycle strobe: ss_n deasserted before DATA_WIDTH bits

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_busy=0, rx_data=0, rx_valid=0, frame_error=0, state=WAIT_END, bit_cnt=0, tx_buf=IDLE_WORD, tx_pending=0.
- Synchronisation:
  - sclk, ss_n and mosi each pass through 2 flops. A third flop gives edge detection.
  - Detected events (sclk rise/fall, ss_n fall/rise) are single-cycle, 3 clk after the pin change.
  - mosi is sampled from its synchronised copy on the sclk-rise event.
- Transmit buffer:
  - tx_load captures tx_data into tx_buf and sets tx_pending, in any state. A later load overwrites an earlier one.
  - At frame start the shift register takes tx_buf if tx_pending is set, else IDLE_WORD. tx_pending then clears.
  - If tx_load coincides with the ss_n-fall event, tx_data (bypass) is used and tx_pending stays 0.
- State machine:
  - IDLE: ss_n-fall event -> ACTIVE. On entry: load the shift register, drive MSB on miso, miso_oe=1, tx_busy=1, bit_cnt=0.
  - ACTIVE:
    - sclk rise: shift the synchronised mosi into rx_shift LSB; bit_cnt+1.
    - sclk fall: shift tx left; miso = new MSB.
    - When bit_cnt reaches DATA_WIDTH on a rise: the next cycle, rx_data <= rx_shift, rx_valid=1 for 1 cycle, state -> WAIT_END. Latency is 4 clk from the final sclk pin rise.
    - ss_n-rise event with bit_cnt < DATA_WIDTH: frame_error=1 for 1 cycle, rx_data unchanged, no rx_valid, -> IDLE.
  - WAIT_END:
    - Further sclk edges are ignored. miso holds 0 and miso_oe stays 1 while ss_n is low.
    - ss_n-rise event -> IDLE, no error.
    - This is also the reset state: if ss_n is low when reset releases, that partial frame is skipped without error.
  - Leaving ACTIVE or WAIT_END to IDLE: miso_oe=0, miso=0, tx_busy=0, bit_cnt=0.
- Simultaneous events: if ss_n-rise and the final sclk-rise events fall in the same cycle, the frame completes (rx_valid, no frame_error). A frame completion is never lost to an ss_n rise.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). rx_valid and frame_error are not emitted.
- rx_valid has no backpressure. rx_data holds until the next completed frame.
- Timing constraint: each sclk high and low phase must be >= 5 clk. This keeps miso updated (4 clk after the fall pin edge) before the master's next sampling edge.

Test Plan:
- Basic frame: tx_load with tx_data=32'hA5A5_0F0F. Master sends 32'h1234_5678 with sclk = clk/12. -> rx_valid pulses once, rx_data=32'h1234_5678; master receives 32'hA5A5_0F0F; tx_busy high for the whole frame.
- Back-to-back: two frames, no tx_load before the second, IDLE_WORD=0. -> Second frame returns 32'h0000_0000. Two rx_valid pulses with the correct words 32'hDEAD_BEEF and 32'hCAFE_F00D.
- Abort: ss_n raised after 17 bits of 32'hFFFF_FFFF. -> frame_error for 1 cycle, no rx_valid, rx_data keeps its previous value. The next full frame 32'h0000_0001 is received correctly.
- Over-clocking: master sends 40 sclk cycles in one frame. -> rx_data = the first 32 bits, exactly one rx_valid, no frame_error, miso=0 during extra bits.
- Reset mid-frame: assert reset after bit 10, release with ss_n still low. -> Outputs at reset values; remaining bits ignored; no strobes. The next frame after ss_n rises works normally.
- Load race: tx_load (32'h8000_0001) in the same cycle as the ss_n-fall event. -> Master receives 32'h8000_0001; tx_pending=0 afterwards, so the next frame sends IDLE_WORD.
